gain_stage: RTL
===============

# gain_stage

Applies the user volume setting to the stereo audio path. It consumes the signed `gain` word from the front-panel volume logic and one stereo sample frame at a time from the effects chain. It multiplies both channels by a smoothed copy of the gain, saturates the results, and presents them to the output/codec side. Gain changes ramp one step at a time to avoid zipper noise.

## Interface
- `DATA_W`, 24: sample width, signed two's complement.
- `GAIN_MAX`, 50: upper clamp for the gain; the lower clamp is fixed at 1.
- `RAMP_FRAMES`, 16: accepted frames per one-step gain move; must be ≥1.

- `CLK` in 1: single clock; all state is on its rising edge.
- `RESET_N` in 1: asynchronous, active-low reset.
- `gain` in 32: signed target gain, sampled every cycle with no handshake.
- `in_valid` in 1: a frame is present on `in_left`/`in_right`.
- `in_ready` out 1: block can accept a frame.
- `in_left` in DATA_W: signed left sample.
- `in_right` in DATA_W: signed right sample.
- `out_valid` out 1: one-cycle pulse; the output frame is valid.
- `out_left` out DATA_W: scaled, saturated left sample.
- `out_right` out DATA_W: scaled, saturated right sample.
- `clipped` out 1: qualified by `out_valid`; high if either channel saturated.
- `cur_gain` out 8: gain currently applied, for display.

## Operation
- **Target clamp**, evaluated every cycle:
  - `gain` < 1 → 1.
  - `gain` > GAIN_MAX → GAIN_MAX.
  - Otherwise `gain`, as-is.
  - Negative and huge values must clamp correctly, so the compare is signed and full width.
- **Smoothing:**
  - The ramp counter increments on each accepted frame.
  - When it reaches RAMP_FRAMES−1, on that accept it wraps to 0 and `cur_gain` moves ±1 toward the clamped target. There is no move if they are equal.
  - There is never a jump larger than 1 per step.
  - The counter keeps running while `cur_gain` equals the target.
- **FSM states:**
  - IDLE: `in_ready`=1. On `in_valid`, capture both samples and apply any gain step, then go to MUL_L.
  - MUL_L: left product = left × `cur_gain` (post-step value), saturated and registered. Go to MUL_R.
  - MUL_R: the same for right. Go to OUT.
  - OUT: `out_valid`=1 and `clipped` = OR of both saturation events. Return to IDLE.
- **Multiplier:** one signed multiplier is shared between the two channels. The product width is DATA_W+8.
- **Saturation:**
  - Products > 2^(DATA_W−1)−1 → 2^(DATA_W−1)−1.
  - Products < −2^(DATA_W−1) → −2^(DATA_W−1).
  - Otherwise the low DATA_W bits.
- **Holding:** `out_left`/`out_right` hold their last value between pulses.
- **Frames while busy:** `in_valid` outside IDLE is ignored. The source must hold the frame until `in_ready`.
- **Reset:** asynchronous at any point, including mid-frame. A partially processed frame is discarded, and no `out_valid` is produced for it.

## Timing
- Accept in cycle T (`in_valid`&&`in_ready`). `out_valid` is high in cycle T+3 only. `in_ready` returns high in T+4.
- Maximum throughput is 1 frame per 4 cycles.
- A gain step takes effect on the frame accepted in the same cycle.
- A change on `gain` is reflected in the clamp the same cycle. It affects `cur_gain` only at the next step point.
- Reset values:
  - state IDLE, so `in_ready`=1 during and after reset.
  - `out_valid`=0.
  - `out_left`=`out_right`=0.
  - `clipped`=0.
  - `cur_gain`=1.
  - ramp counter 0.

## Test plan
- **Reset, then unity gain:** hold RESET_N low, then release with `gain`=1, RAMP_FRAMES=1. Check `in_ready`=1, outputs 0, `cur_gain`=1. Send left=1000, right=−1000 → `out_valid` exactly 3 cycles later, 1000/−1000, `clipped`=0.
- **Ramp:** RAMP_FRAMES=1, set `gain`=4, send 5 frames of left=1000 → left outputs 2000, 3000, 4000, 4000, 4000. Then `gain`=2 → next outputs 3000, 2000.
- **Ramp divider:** RAMP_FRAMES=16, `gain` 1→3 → `cur_gain` becomes 2 on the 16th accepted frame and 3 on the 32nd.
- **Saturation:** `cur_gain`=50, left=200000, right=−200000 → 8388607 / −8388608, `clipped`=1. Left=100000 → 5000000, `clipped`=0.
- **Clamp:** `gain`=0, then −7, then 1000, then 0x7FFFFFFF with RAMP_FRAMES=1 → `cur_gain` never drops below 1 and settles at 50.
- **Backpressure and reset:**
  - Hold `in_valid` high with changing data → a frame is accepted only every 4th cycle, and the outputs match the sampled frames.
  - Assert RESET_N in MUL_R → no `out_valid`, all outputs reset, and the next frame is processed normally.

Source files
------------

// File: rtl/gain_stage.sv
// Stereo volume stage: clamps the requested gain, ramps the applied gain one
// step per RAMP_FRAMES frames, and scales both channels through one shared multiplier.
module gain_stage #(
  parameter int DATA_W      = 24,
  parameter int GAIN_MAX    = 50,
  parameter int RAMP_FRAMES = 16
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic signed [31:0]       gain,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_left,
  input  logic signed [DATA_W-1:0] in_right,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_left,
  output logic signed [DATA_W-1:0] out_right,
  output logic                     clipped,
  output logic [7:0]               cur_gain
);

  localparam int PROD_W = DATA_W + 8;
  localparam int CNT_W  = (RAMP_FRAMES > 1) ? $clog2(RAMP_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAMP_FRAMES - 1);
  localparam logic signed [DATA_W-1:0] OUT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] OUT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [31:0] GAIN_HI = 32'(GAIN_MAX);

  typedef enum logic [1:0] {IDLE, MUL_L, MUL_R, OUT} state_t;

  state_t                     state_reg;
  logic [CNT_W-1:0]           ramp_cnt_reg;
  logic signed [DATA_W-1:0]   left_reg;
  logic signed [DATA_W-1:0]   right_reg;
  logic signed [DATA_W-1:0]   left_prod_reg;
  logic                       left_clip_reg;

  logic [7:0]                 target;
  logic signed [DATA_W-1:0]   mul_a;
  logic signed [PROD_W-1:0]   prod;
  logic signed [DATA_W-1:0]   sat_val;
  logic                       sat_ovf;

  // Full-width signed compare so negative and huge requests clamp correctly.
  always_comb begin
    target = gain[7:0];
    if (gain < 32'sd1)
      target = 8'd1;
    else if (gain > GAIN_HI)
      target = GAIN_HI[7:0];
  end

  assign mul_a = (state_reg == MUL_L) ? left_reg : right_reg;
  assign prod  = PROD_W'(mul_a) * PROD_W'($signed(cur_gain));

  always_comb begin
    sat_val = prod[DATA_W-1:0];
    sat_ovf = 1'b0;
    if (prod > PROD_W'(OUT_MAX)) begin
      sat_val = OUT_MAX;
      sat_ovf = 1'b1;
    end else if (prod < PROD_W'(OUT_MIN)) begin
      sat_val = OUT_MIN;
      sat_ovf = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg     <= IDLE;
      ramp_cnt_reg  <= '0;
      left_reg      <= '0;
      right_reg     <= '0;
      left_prod_reg <= '0;
      left_clip_reg <= 1'b0;
      in_ready      <= 1'b1;
      out_valid     <= 1'b0;
      out_left      <= '0;
      out_right     <= '0;
      clipped       <= 1'b0;
      cur_gain      <= 8'd1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            left_reg  <= in_left;
            right_reg <= in_right;
            in_ready  <= 1'b0;
            state_reg <= MUL_L;
            // The step lands before MUL_L, so this frame already uses it.
            if (ramp_cnt_reg == CNT_LAST) begin
              ramp_cnt_reg <= '0;
              if (cur_gain < target)
                cur_gain <= cur_gain + 8'd1;
              else if (cur_gain > target)
                cur_gain <= cur_gain - 8'd1;
            end else begin
              ramp_cnt_reg <= ramp_cnt_reg + 1'b1;
            end
          end
        end
        MUL_L: begin
          left_prod_reg <= sat_val;
          left_clip_reg <= sat_ovf;
          state_reg     <= MUL_R;
        end
        MUL_R: begin
          out_left  <= left_prod_reg;
          out_right <= sat_val;
          clipped   <= left_clip_reg | sat_ovf;
          out_valid <= 1'b1;
          state_reg <= OUT;
        end
        OUT: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
